preg_alloc_ctrl: RTL and testbench
==================================

Name: preg_alloc_ctrl

Overview:
Controller for the physical-register free list consumed by the uop decode/rename stage. It holds the free physical register numbers in a circular queue and grants up to 2 pregs per cycle to rename. It accepts up to 2 freed pregs per cycle from commit. It snapshots the allocation head per branch tag and restores it on branch shootdown, rolling back speculative allocations.

Parameters:
NUM_PREGS, 64, total physical registers.
NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset and never start in the free list.
MAX_PREDICT_DEPTH, 4, number of branch checkpoint slots; tag width MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH).
Constraint: FL_DEPTH = NUM_PREGS-NUM_AREGS must be a power of two and at least 2.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset; reset==0 at posedge clears state.
alloc_count  input  2  number of pregs requested this cycle (0,1,2; 3 is treated as 2).
alloc_grant  output  1  comb; request accepted this cycle.
alloc_preg1  output  $clog2(NUM_PREGS)  comb; queue entry at head.
alloc_preg2  output  $clog2(NUM_PREGS)  comb; queue entry at head+1.
num_free  output  $clog2(FL_DEPTH)+1  registered occupancy (tail-head).
free_valid1 / free_preg1  input  1 / $clog2(NUM_PREGS)  commit free slot 1.
free_valid2 / free_preg2  input  1 / $clog2(NUM_PREGS)  commit free slot 2.
ckpt_valid  input  1  save head for ckpt_tag this cycle.
ckpt_tag  input  MAX_PREDICT_DEPTH_BITS  slot to save.
shootdown  input  1  restore head from shootdown_tag.
shootdown_tag  input  MAX_PREDICT_DEPTH_BITS  slot to restore.
double_free  output  1  sticky error flag; see Optional Feature.

Behaviour:
- Storage: fl[FL_DEPTH] of preg numbers. head and tail are $clog2(FL_DEPTH)+1 bits; the MSB is the wrap bit. Index = low bits. num_free = tail-head (modular).
- Reset: fl[i]=NUM_AREGS+i; head=0; tail=FL_DEPTH (wrap=1, index 0); num_free=FL_DEPTH; all checkpoints=0; double_free=0. Outputs are valid from the first cycle after reset deasserts.
- Grant: alloc_grant = shootdown==0 && req<=num_free, where req=min(alloc_count,2). alloc_count==0 gives alloc_grant=1 and consumes nothing.
- On grant, head advances by req at posedge. alloc_preg1/2 are always driven from the current head, even when not granted. The user reads them in the grant cycle; there is zero-cycle latency to the data.
- Free: entries are written at tail and compacted. A valid1 write goes to tail, then a valid2 write goes to the next slot (or to tail if valid1==0). Tail advances by the number of valid frees.
- Frees cannot overflow when the caller is legal. A free that would make num_free exceed FL_DEPTH is dropped.
- Freed pregs are visible for allocation the next cycle, not in the same cycle.
- Checkpoint: ckpt[ckpt_tag] <= head value after this cycle's grant. This means a branch and its allocations in the same cycle are kept on restore.
- Shootdown: head <= ckpt[shootdown_tag]; the alloc request is not granted. Frees in the same cycle are still applied to tail. ckpt_valid in the same cycle is ignored.
- Simultaneous grant and free: head and tail update independently; num_free = old - req + nfree.
- Full (num_free==FL_DEPTH) with alloc: normal grant.
- Empty: only alloc_count==0 is granted.
- Reset asserted mid-operation overrides shootdown, frees and allocs in that cycle.
- Wrap: pointers wrap modulo 2*FL_DEPTH. Index arithmetic wraps modulo FL_DEPTH, including the head+1 read and the tail+1 write.

Optional Feature:
PREG_ALLOC_DOUBLE_FREE_CHECK_EN
- Defined: keep a NUM_PREGS-bit in_list vector. Reset value is 1 for pregs >= NUM_AREGS and 0 otherwise.
  - A grant clears the bits of the granted pregs.
  - A free of a preg whose bit is already 1 is dropped (tail does not advance for it) and sets double_free sticky until reset.
  - free_preg1==free_preg2 with both valid counts as a double free of slot 2.
  - A shootdown sets the bits of the pregs between the restored head and the old head.
- Not defined: no vector; double_free is tied to 0; every valid free is accepted.

Test Plan:
- Reset with NUM_PREGS=64, NUM_AREGS=32 -> num_free=32, alloc_preg1=32, alloc_preg2=33; alloc_count=2 granted -> next cycle alloc_preg1=34, num_free=30.
- Drain with alloc_count=2 for 16 cycles -> num_free=0. Then alloc_count=1 -> alloc_grant=0. Then free_valid1 with preg 5 -> next cycle num_free=1, alloc_preg1=5.
- ckpt_valid tag 2 together with an alloc of 2 at head=4, then 3 more allocs of 2 -> shootdown tag 2 -> head=6, num_free restored to 26, alloc_grant=0 in the shootdown cycle.
- Shootdown in the same cycle as free_valid1=1, free_valid2=1 (pregs 40,41) -> head restored and tail += 2 in the same cycle.
- Wrap: repeatedly allocate and free for 100 cycles -> no preg lost; num_free is constant at its steady value, and the set of allocated plus free pregs equals 32..63.
- With the macro defined: free preg 40 while it is in the list -> double_free=1 and num_free unchanged. Without the macro -> double_free stays 0.

Source files
------------

// File: rtl/preg_alloc_ctrl.sv
// Physical-register free list controller for the rename stage.
// Circular queue of free preg numbers: grants up to 2 pregs per cycle from
// the head, accepts up to 2 freed pregs per cycle at the tail, and keeps a
// per-branch-tag snapshot of the head so a shootdown rolls back speculative
// allocations.
// Optional build macro: PREG_ALLOC_DOUBLE_FREE_CHECK_EN enables tracking of
// which pregs are currently in the list so duplicate frees are dropped and
// flagged on double_free.
module preg_alloc_ctrl #(
  parameter int unsigned NUM_PREGS         = 64,
  parameter int unsigned NUM_AREGS         = 32,
  parameter int unsigned MAX_PREDICT_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [1:0]                                    alloc_count,
  output logic                                          alloc_grant,
  output logic [$clog2(NUM_PREGS)-1:0]                  alloc_preg1,
  output logic [$clog2(NUM_PREGS)-1:0]                  alloc_preg2,
  output logic [$clog2(NUM_PREGS-NUM_AREGS):0]          num_free,
  input  logic                                          free_valid1,
  input  logic [$clog2(NUM_PREGS)-1:0]                  free_preg1,
  input  logic                                          free_valid2,
  input  logic [$clog2(NUM_PREGS)-1:0]                  free_preg2,
  input  logic                                          ckpt_valid,
  input  logic [$clog2(MAX_PREDICT_DEPTH)-1:0]          ckpt_tag,
  input  logic                                          shootdown,
  input  logic [$clog2(MAX_PREDICT_DEPTH)-1:0]          shootdown_tag,
  output logic                                          double_free
);

  localparam int unsigned FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int unsigned IDX_W    = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W    = IDX_W + 1;
  localparam int unsigned PREG_W   = $clog2(NUM_PREGS);

  logic [PREG_W-1:0] fl   [FL_DEPTH];
  logic [PTR_W-1:0]  ckpt [MAX_PREDICT_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic [1:0]        req;
  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;
  logic [IDX_W-1:0]  wr_idx2;
  logic [PTR_W-1:0]  space;
  logic              ok1;
  logic              ok2;
  logic              acc1;
  logic              acc2;
  logic [PTR_W-1:0]  head_n;
  logic [PTR_W-1:0]  tail_n;

  // Grant decision and zero-latency read of the two head entries
  always_comb begin
    req         = (alloc_count == 2'd3) ? 2'd2 : alloc_count;
    head_idx    = head[IDX_W-1:0];
    alloc_grant = !shootdown && (PTR_W'(req) <= num_free);
    alloc_preg1 = fl[head_idx];
    alloc_preg2 = fl[head_idx + IDX_W'(1)];
  end

`ifdef PREG_ALLOC_DOUBLE_FREE_CHECK_EN
  logic [NUM_PREGS-1:0] in_list;
  logic [NUM_PREGS-1:0] in_list_n;
  logic                 dup1;
  logic                 dup2;
  logic [PTR_W-1:0]     rb_ptr;
  logic [PTR_W-1:0]     rb_len;
  logic [IDX_W-1:0]     rb_off;

  // Reject frees of pregs already sitting in the list; slot 2 duplicating slot 1 counts too
  always_comb begin
    dup1 = free_valid1 && in_list[free_preg1];
    dup2 = free_valid2 && (in_list[free_preg2] ||
                           (free_valid1 && (free_preg1 == free_preg2)));
    ok1  = free_valid1 && !dup1;
    ok2  = free_valid2 && !dup2;
  end

  // Membership update: grants clear, rolled-back entries and accepted frees set
  always_comb begin
    in_list_n = in_list;
    rb_ptr    = ckpt[shootdown_tag];
    rb_len    = head - rb_ptr;
    rb_off    = '0;
    if (alloc_grant && (req != 2'd0)) in_list_n[alloc_preg1] = 1'b0;
    if (alloc_grant && (req == 2'd2)) in_list_n[alloc_preg2] = 1'b0;
    if (shootdown) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        rb_off = IDX_W'(i) - rb_ptr[IDX_W-1:0];
        if (PTR_W'(rb_off) < rb_len) in_list_n[fl[IDX_W'(i)]] = 1'b1;
      end
    end
    if (acc1) in_list_n[free_preg1] = 1'b1;
    if (acc2) in_list_n[free_preg2] = 1'b1;
  end

  // Membership vector and sticky error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned p = 0; p < NUM_PREGS; p++) in_list[p] <= (p >= NUM_AREGS);
      double_free <= 1'b0;
    end else begin
      in_list <= in_list_n;
      if (dup1 || dup2) double_free <= 1'b1;
    end
  end
`else
  // Every valid free is accepted when membership is not tracked
  always_comb begin
    ok1 = free_valid1;
    ok2 = free_valid2;
  end

  assign double_free = 1'b0;
`endif

  // Free-slot compaction, overflow drop and next pointer values
  always_comb begin
    tail_idx = tail[IDX_W-1:0];
    space    = PTR_W'(FL_DEPTH) - num_free;
    acc1     = ok1 && (space != '0);
    acc2     = ok2 && (space > PTR_W'(acc1));
    wr_idx2  = tail_idx + IDX_W'(acc1);
    tail_n   = tail + PTR_W'(acc1) + PTR_W'(acc2);
    if (shootdown)        head_n = ckpt[shootdown_tag];
    else if (alloc_grant) head_n = head + PTR_W'(req);
    else                  head_n = head;
  end

  // Queue storage, pointers, occupancy and branch checkpoints
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) fl[i] <= PREG_W'(NUM_AREGS + i);
      for (int unsigned t = 0; t < MAX_PREDICT_DEPTH; t++) ckpt[t] <= '0;
      head     <= '0;
      tail     <= PTR_W'(FL_DEPTH);
      num_free <= PTR_W'(FL_DEPTH);
    end else begin
      if (acc1) fl[tail_idx] <= free_preg1;
      if (acc2) fl[wr_idx2]  <= free_preg2;
      if (ckpt_valid && !shootdown) ckpt[ckpt_tag] <= head_n;
      head     <= head_n;
      tail     <= tail_n;
      num_free <= tail_n - head_n;
    end
  end

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Self-checking bench for preg_alloc_ctrl: directed vector tables plus
// hand-written sequences for reset override, double free and pointer wrap.
module tb_preg_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] alloc_count;
  logic       alloc_grant;
  logic [5:0] alloc_preg1;
  logic [5:0] alloc_preg2;
  logic [5:0] num_free;
  logic       free_valid1;
  logic [5:0] free_preg1;
  logic       free_valid2;
  logic [5:0] free_preg2;
  logic       ckpt_valid;
  logic [1:0] ckpt_tag;
  logic       shootdown;
  logic [1:0] shootdown_tag;
  logic       double_free;

  int n_tests = 0;
  int n_fail  = 0;

  preg_alloc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_count  (alloc_count),
    .alloc_grant  (alloc_grant),
    .alloc_preg1  (alloc_preg1),
    .alloc_preg2  (alloc_preg2),
    .num_free     (num_free),
    .free_valid1  (free_valid1),
    .free_preg1   (free_preg1),
    .free_valid2  (free_valid2),
    .free_preg2   (free_preg2),
    .ckpt_valid   (ckpt_valid),
    .ckpt_tag     (ckpt_tag),
    .shootdown    (shootdown),
    .shootdown_tag(shootdown_tag),
    .double_free  (double_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ac;
    logic       fv1;
    logic [5:0] fp1;
    logic       fv2;
    logic [5:0] fp2;
    logic       cv;
    logic [1:0] ct;
    logic       sd;
    logic [1:0] st;
    logic       eg;
    logic [5:0] ep1;
    logic [5:0] ep2;
    logic [5:0] enf;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] ac, input logic fv1, input int fp1,
                     input logic fv2, input int fp2, input logic cv, input int ct,
                     input logic sd, input int st, input logic eg, input int ep1,
                     input int ep2, input int enf);
    vec_t v;
    v.ac = ac; v.fv1 = fv1; v.fp1 = 6'(fp1); v.fv2 = fv2; v.fp2 = 6'(fp2);
    v.cv = cv; v.ct = 2'(ct); v.sd = sd; v.st = 2'(st);
    v.eg = eg; v.ep1 = 6'(ep1); v.ep2 = 6'(ep2); v.enf = 6'(enf);
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    alloc_count = 2'd0; free_valid1 = 1'b0; free_preg1 = '0;
    free_valid2 = 1'b0; free_preg2 = '0; ckpt_valid = 1'b0; ckpt_tag = '0;
    shootdown = 1'b0; shootdown_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Apply every queued vector; outputs are sampled on the falling edge
  task automatic run_vecs(input string tname);
    for (int i = 0; i < vq.size(); i++) begin
      alloc_count = vq[i].ac; free_valid1 = vq[i].fv1; free_preg1 = vq[i].fp1;
      free_valid2 = vq[i].fv2; free_preg2 = vq[i].fp2; ckpt_valid = vq[i].cv;
      ckpt_tag = vq[i].ct; shootdown = vq[i].sd; shootdown_tag = vq[i].st;
      @(negedge clk);
      chk($sformatf("%s[%0d].grant", tname, i), int'(alloc_grant), int'(vq[i].eg));
      chk($sformatf("%s[%0d].preg1", tname, i), int'(alloc_preg1), int'(vq[i].ep1));
      chk($sformatf("%s[%0d].preg2", tname, i), int'(alloc_preg2), int'(vq[i].ep2));
      chk($sformatf("%s[%0d].num_free", tname, i), int'(num_free), int'(vq[i].enf));
      @(posedge clk); #1;
    end
    vq.delete();
    idle_inputs();
  endtask

  int model_q[$];
  int prev0, prev1, a, b;
  bit have_prev;
  bit seen [64];
  int n_seen;
  bit bad_seen;

  initial begin
    idle_inputs();
    reset = 1'b0;

    // Checkpoint / shootdown table
    do_reset();
    //   ac  fv1 fp1 fv2 fp2 cv ct sd st  eg p1  p2  nf
    add(2'd2, 0, 0,  0, 0,  0, 0, 0, 0,  1, 32, 33, 32);
    add(2'd2, 0, 0,  0, 0,  1, 1, 0, 0,  1, 34, 35, 30);
    add(2'd2, 0, 0,  0, 0,  1, 2, 0, 0,  1, 36, 37, 28);
    add(2'd2, 0, 0,  0, 0,  0, 0, 0, 0,  1, 38, 39, 26);
    add(2'd2, 0, 0,  0, 0,  0, 0, 0, 0,  1, 40, 41, 24);
    add(2'd2, 0, 0,  0, 0,  0, 0, 0, 0,  1, 42, 43, 22);
    add(2'd2, 0, 0,  0, 0,  1, 3, 1, 2,  0, 44, 45, 20);
    add(2'd0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 38, 39, 26);
    add(2'd3, 0, 0,  0, 0,  0, 0, 0, 0,  1, 38, 39, 26);
    add(2'd1, 1, 2,  1, 3,  0, 0, 1, 1,  0, 40, 41, 24);
    add(2'd0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 36, 37, 30);
    add(2'd2, 0, 0,  0, 0,  0, 0, 0, 0,  1, 36, 37, 30);
    run_vecs("ckpt");
    chk("ckpt.double_free", int'(double_free), 0);

    // Reset asserted together with alloc, free and shootdown wins
    alloc_count = 2'd2; free_valid1 = 1'b1; free_preg1 = 6'd9;
    shootdown = 1'b1; shootdown_tag = 2'd1; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; idle_inputs();
    @(negedge clk);
    chk("midreset.num_free", int'(num_free), 32);
    chk("midreset.preg1", int'(alloc_preg1), 32);
    chk("midreset.preg2", int'(alloc_preg2), 33);
    chk("midreset.grant", int'(alloc_grant), 1);
    @(posedge clk); #1;

    // Overflow drop, drain to empty, refill and compaction table
    do_reset();
    add(2'd0, 1, 3,  1, 4,  0, 0, 0, 0,  1, 32, 33, 32);
    for (int k = 0; k < 16; k++)
      add(2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k);
    add(2'd1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 32, 33, 0);
    add(2'd0, 1, 5,  0, 0,  0, 0, 0, 0,  1, 32, 33, 0);
    add(2'd2, 0, 0,  0, 0,  0, 0, 0, 0,  0, 5,  33, 1);
    add(2'd1, 0, 0,  0, 0,  0, 0, 0, 0,  1, 5,  33, 1);
    add(2'd0, 1, 6,  1, 7,  0, 0, 0, 0,  1, 33, 34, 0);
    add(2'd0, 0, 0,  1, 8,  0, 0, 0, 0,  1, 6,  7,  2);
    add(2'd2, 0, 0,  0, 0,  0, 0, 0, 0,  1, 6,  7,  3);
    add(2'd1, 0, 0,  0, 0,  0, 0, 0, 0,  1, 8,  36, 1);
    add(2'd0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 36, 37, 0);
    run_vecs("drain");

    // Freeing a preg that is still in the list
    do_reset();
    alloc_count = 2'd2;
    @(posedge clk); #1;
    idle_inputs(); free_valid1 = 1'b1; free_preg1 = 6'd40;
    @(negedge clk);
    chk("dfree.nf_before", int'(num_free), 30);
    @(posedge clk); #1;
    idle_inputs(); free_valid1 = 1'b1; free_preg1 = 6'd32;
    @(negedge clk);
`ifdef PREG_ALLOC_DOUBLE_FREE_CHECK_EN
    chk("dfree.nf_after", int'(num_free), 30);
    chk("dfree.flag", int'(double_free), 1);
`else
    chk("dfree.nf_after", int'(num_free), 31);
    chk("dfree.flag", int'(double_free), 0);
`endif
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
`ifdef PREG_ALLOC_DOUBLE_FREE_CHECK_EN
    chk("dfree.legal_free_nf", int'(num_free), 31);
    chk("dfree.sticky", int'(double_free), 1);
`else
    chk("dfree.legal_free_nf", int'(num_free), 32);
    chk("dfree.sticky", int'(double_free), 0);
`endif
    @(posedge clk); #1;

    // Steady allocate/free traffic across many pointer wraps
    do_reset();
    model_q.delete();
    for (int p = 32; p < 64; p++) model_q.push_back(p);
    have_prev = 1'b0;
    prev0 = 0; prev1 = 0;
    for (int k = 0; k < 100; k++) begin
      alloc_count = 2'd2;
      free_valid1 = have_prev; free_preg1 = 6'(prev0);
      free_valid2 = have_prev; free_preg2 = 6'(prev1);
      @(negedge clk);
      chk($sformatf("wrap[%0d].grant", k), int'(alloc_grant), 1);
      chk($sformatf("wrap[%0d].num_free", k), int'(num_free), model_q.size());
      chk($sformatf("wrap[%0d].preg1", k), int'(alloc_preg1), model_q[0]);
      chk($sformatf("wrap[%0d].preg2", k), int'(alloc_preg2), model_q[1]);
      a = model_q.pop_front();
      b = model_q.pop_front();
      if (have_prev) begin
        model_q.push_back(prev0);
        model_q.push_back(prev1);
      end
      prev0 = a; prev1 = b; have_prev = 1'b1;
      @(posedge clk); #1;
    end
    idle_inputs();
    free_valid1 = 1'b1; free_preg1 = 6'(prev0);
    free_valid2 = 1'b1; free_preg2 = 6'(prev1);
    model_q.push_back(prev0);
    model_q.push_back(prev1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("wrap.final_num_free", int'(num_free), 32);
    @(posedge clk); #1;
    for (int p = 0; p < 64; p++) seen[p] = 1'b0;
    bad_seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      alloc_count = 2'd2;
      @(negedge clk);
      chk($sformatf("wrapdrain[%0d].preg1", k), int'(alloc_preg1), model_q[2 * k]);
      chk($sformatf("wrapdrain[%0d].preg2", k), int'(alloc_preg2), model_q[2 * k + 1]);
      if (seen[alloc_preg1] || alloc_preg1 < 6'd32) bad_seen = 1'b1;
      seen[alloc_preg1] = 1'b1;
      if (seen[alloc_preg2] || alloc_preg2 < 6'd32) bad_seen = 1'b1;
      seen[alloc_preg2] = 1'b1;
      @(posedge clk); #1;
    end
    idle_inputs();
    n_seen = 0;
    for (int p = 32; p < 64; p++) if (seen[p]) n_seen++;
    chk("wrap.distinct_pregs", n_seen, 32);
    chk("wrap.no_dup_or_arch", int'(bad_seen), 0);
    @(negedge clk);
    chk("wrap.empty", int'(num_free), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
